dmem_access_unit: RTL and testbench

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

---
 rtl/dmem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
`timescale 1ns/1ps
// dmem_access_unit: MA-stage load/store engine driving a word-wide data-memory initiator port.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of truncating them.
module dmem_access_unit #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        done,
   output logic        fault,
   output logic [31:0] load_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [1:0]    lane_r, lane_s;
   logic [2:0]    f3_r, f3_s;
   logic          start_s, bad_f3_s, misalign_s, illegal_s;
   logic          req_s, we_s, done_s, fault_s;
   logic [31:0]   maddr_s, wdata_s, ld_s;
   logic [3:0]    be_s;

   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lane);
      case (f3)
         3'b000, 3'b100: lane_mask = 4'b0001 << lane;
         3'b001, 3'b101: lane_mask = 4'b0011 << {lane[1], 1'b0};
         3'b010:         lane_mask = 4'b1111;
         default:        lane_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   replicate = {4{d[7:0]}};
         2'b01:   replicate = {2{d[15:0]}};
         default: replicate = d;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{lane, 3'b000} +: 8];
      h = rd[{lane[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b100:  extract = {24'd0, b};
         3'b101:  extract = {16'd0, h};
         default: extract = rd;
      endcase
   endfunction

   // Request decode: legal start, illegal encodings and optional misalignment trap.
   always_comb begin
      start_s  = valid_in & (is_load ^ is_store);
      bad_f3_s = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_s = ((funct3[1:0] == 2'b01) & addr[0]) |
                   ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
      misalign_s = 1'b0;
`endif
      illegal_s = (valid_in & is_load & is_store) | (start_s & (bad_f3_s | misalign_s));
      stall     = (state_r == ACCESS) | ((state_r == IDLE) & start_s);
   end

   // Next-state and next-output logic; every register holds unless a branch changes it.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      lane_s  = lane_r;
      f3_s    = f3_r;
      req_s   = mem_req;
      we_s    = mem_we;
      maddr_s = mem_addr;
      be_s    = mem_be;
      wdata_s = mem_wdata;
      ld_s    = load_data;
      done_s  = 1'b0;
      fault_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (illegal_s) begin
               done_s  = 1'b1;
               fault_s = 1'b1;
            end else if (start_s) begin
               state_s = ACCESS;
               cnt_s   = '0;
               req_s   = 1'b1;
               we_s    = is_store;
               maddr_s = {addr[31:2], 2'b00};
               be_s    = lane_mask(funct3, addr[1:0]);
               wdata_s = replicate(funct3, store_data);
               lane_s  = addr[1:0];
               f3_s    = funct3;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_s = IDLE;
               req_s   = 1'b0;
               done_s  = 1'b1;
               if (!mem_we) begin
                  ld_s = extract(f3_r, lane_r, mem_rdata);
               end else begin
                  ld_s = load_data;
               end
            end else if (cnt_r == CW'(ACK_TIMEOUT - 1)) begin
               state_s = IDLE;
               req_s   = 1'b0;
               done_s  = 1'b1;
               fault_s = 1'b1;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            req_s   = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Registered outputs, timeout counter and latched access attributes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r     <= '0;
         lane_r    <= 2'b00;
         f3_r      <= 3'b000;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'd0;
         done      <= 1'b0;
         fault     <= 1'b0;
         load_data <= 32'd0;
      end else begin
         cnt_r     <= cnt_s;
         lane_r    <= lane_s;
         f3_r      <= f3_s;
         mem_req   <= req_s;
         mem_we    <= we_s;
         mem_addr  <= maddr_s;
         mem_be    <= be_s;
         mem_wdata <= wdata_s;
         done      <= done_s;
         fault     <= fault_s;
         load_data <= ld_s;
      end
   end
endmodule

// File: tb/tb_dmem_access_unit.sv
`timescale 1ns/1ps
// tb_dmem_access_unit: directed plus randomized accesses checked against a byte-level reference model.
module tb_dmem_access_unit;
   localparam int TO = 15;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, valid_in, is_load, is_store, mem_ack;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data, mem_rdata;
   logic        stall, done, fault, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ld;

   always #5 clk = ~clk;

   dmem_access_unit #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .done(done),
      .fault(fault), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access from the start cycle through the cycle after done; delay >= TO means no ack.
   task automatic do_access(input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int delay);
      bit          legal, illegal, timeout;
      int          size, off, nreq;
      logic [3:0]  ebe;
      logic [31:0] ewd, eld;
      legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      size  = 4;
      off   = 0;
      if (legal) begin
         size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
         off  = int'(a[1:0]) - (int'(a[1:0]) % size);
      end
      illegal = (ld && st) || !legal || (TRAP && ((int'(a[1:0]) % size) != 0));
      ebe = 4'(((32'd1 << size) - 32'd1) << off);
      for (int k = 0; k < 4; k++) ewd[8*k +: 8] = sd[8*(k % size) +: 8];
      eld = rd >> (8 * off);
      if (size < 4) eld = eld & ((32'd1 << (8 * size)) - 32'd1);
      if (size < 4 && !f3[2] && eld[8*size-1]) eld = eld - (32'd1 << (8 * size));
      timeout = (delay >= TO);
      nreq    = timeout ? TO : delay + 1;

      valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a;
      store_data = sd; mem_ack = 1'b0;
      #1;
      check1("stall_start", stall, ld ^ st);
      tick();
      valid_in = 1'b0;
      if (illegal) begin
         check1("illegal_done", done, 1'b1);
         check1("illegal_fault", fault, 1'b1);
         check1("illegal_noreq", mem_req, 1'b0);
      end else begin
         for (int k = 0; k < nreq; k++) begin
            valid_in = 1'($urandom); is_load = 1'($urandom); is_store = 1'($urandom);
            funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
            check1("req_high", mem_req, 1'b1);
            check1("busy_no_done", done, 1'b0);
            check1("req_we", mem_we, st);
            check("req_addr", mem_addr, {a[31:2], 2'b00});
            check("req_be", {28'd0, mem_be}, {28'd0, ebe});
            if (st) check("req_wdata", mem_wdata, ewd);
            #1;
            check1("busy_stall", stall, 1'b1);
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rd : $urandom;
            tick();
         end
         valid_in = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
         check1("done_pulse", done, 1'b1);
         check1("done_fault", fault, timeout);
         check1("done_req_low", mem_req, 1'b0);
         if (ld && !timeout) exp_ld = eld;
         check("done_load_data", load_data, exp_ld);
      end
      #1;
      check1("done_stall_low", stall, 1'b0);
      tick();
      check1("after_done", done, 1'b0);
      check1("after_fault", fault, 1'b0);
      check("hold_load_data", load_data, exp_ld);
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
      addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
      exp_ld = 32'd0;
      tick();
      tick();
      check1("rst_req", mem_req, 1'b0);
      check1("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_be", {28'd0, mem_be}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check1("rst_done", done, 1'b0);
      check1("rst_fault", fault, 1'b0);
      check("rst_load_data", load_data, 32'd0);
      reset = 1'b0;
      tick();

      do_access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0);
      do_access(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'd0, 32'h12F4_5678, 0);
      check("lb_value", load_data, 32'hFFFF_FFF4);
      do_access(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'd0, 32'h12F4_5678, 2);
      check("lbu_value", load_data, 32'h0000_00F4);
      do_access(1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'd0, 32'h8765_4321, 1);
      do_access(1'b1, 1'b0, 3'b001, 32'h0000_0207, 32'd0, 32'hCAFE_BABE, 0);
      do_access(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0, 32'h1357_9BDF, 0);
      do_access(1'b0, 1'b1, 3'b001, 32'h0000_0402, 32'h1234_BEEF, 32'd0, 3);
      do_access(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'hDEAD_BEEF, 32'd0, 14);
      do_access(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0, 32'h5555_AAAA, TO + 2);
      do_access(1'b1, 1'b1, 3'b010, 32'h0000_0700, 32'd0, 32'd0, 0);
      do_access(1'b1, 1'b0, 3'b011, 32'h0000_0800, 32'd0, 32'd0, 0);

      valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0904;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      check1("pre_reset_req", mem_req, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check1("abort_req", mem_req, 1'b0);
      check1("abort_done", done, 1'b0);
      check1("abort_fault", fault, 1'b0);
      check("abort_be", {28'd0, mem_be}, 32'd0);
      check("abort_load_data", load_data, 32'd0);
      exp_ld = 32'd0;
      do_access(1'b1, 1'b0, 3'b101, 32'h0000_0A02, 32'd0, 32'hF00D_8001, 0);

      for (int i = 0; i < 40; i++) begin
         int r;
         r = int'($urandom_range(0, 7));
         do_access((r >= 1 && r <= 4) || r == 0, (r >= 5) || r == 0, 3'($urandom),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 17)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
